// File: rtl/ftdl_pkg.sv
// Shared types for the activation-buffer ping-pong scheduler: per-half and
// top-level state encodings plus the post-done view of a half.
package ftdl_pkg;

    localparam int TILE_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FILLING   = 2'd1,
        FULL      = 2'd2,
        COMPUTING = 2'd3
    } bank_st_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sched_st_e;

    // State a half will hold once this edge's done pulses are applied; issue
    // decisions are taken against this view so starts follow dones by one cycle.
    function automatic bank_st_e bank_eff(input bank_st_e st,
                                          input logic     set_full,
                                          input logic     set_empty);
        if (set_empty) return EMPTY;
        if (set_full)  return FULL;
        return st;
    endfunction

endpackage

// File: rtl/pp_bank_tracker.sv
// State register for one actbuf half. Done-driven transitions are applied
// first, then a same-edge start (fill or compute) overrides them.
module pp_bank_tracker
    import ftdl_pkg::*;
(
    input  logic     clk_l,
    input  logic     rst_n,
    input  logic     set_fill,
    input  logic     set_full,
    input  logic     set_comp,
    input  logic     set_empty,
    output bank_st_e state
);

    bank_st_e state_nxt;

    always_comb begin
        state_nxt = bank_eff(state, set_full, set_empty);
        if (set_fill) state_nxt = FILLING;
        if (set_comp) state_nxt = COMPUTING;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

endmodule

// File: rtl/actbuf_pp_sched.sv
// Ping-pong scheduler: streams one layer of N tiles through the two actbuf
// halves so that loading tile k+1 overlaps computing tile k.
module actbuf_pp_sched
    import ftdl_pkg::*;
#(
    parameter int TILE_CNT_W = TILE_CNT_W_DEF
) (
    input  logic                  clk_l,
    input  logic                  rst_n,
    input  logic [TILE_CNT_W-1:0] cfg_tile_num,
    input  logic                  layer_start,
    output logic                  ld_start,
    output logic                  ld_bank,
    input  logic                  ld_done,
    output logic                  cmp_start,
    output logic                  cmp_bank,
    input  logic                  cmp_done,
    output logic                  busy,
    output logic                  layer_done,
    output logic                  err_spurious
);

    sched_st_e             st, st_nxt;
    logic [TILE_CNT_W-1:0] tile_num, ld_cnt, cmp_cnt;
    logic                  ld_ptr, cmp_ptr;
    logic                  ld_busy, cmp_busy;

    logic                  ld_done_ok, cmp_done_ok, spurious;
    logic                  accept, run_eff;
    logic [TILE_CNT_W-1:0] n_eff, ld_cnt_eff;
    logic                  ld_ptr_eff, cmp_ptr_eff;
    logic                  ld_issue, cmp_issue;

    logic [1:0]            set_fill, set_full, set_comp, set_empty;
    bank_st_e              bank_st [2];
    bank_st_e              eff     [2];

    assign ld_done_ok  = ld_done & ld_busy;
    assign cmp_done_ok = cmp_done & cmp_busy;
    assign spurious    = (ld_done & ~ld_busy) | (cmp_done & ~cmp_busy);

    // The accepting edge already issues the first load, so counters and
    // pointers are seen as freshly cleared on that edge.
    assign accept      = (st == IDLE) & layer_start & (cfg_tile_num != '0);
    assign run_eff     = (st == RUN) | accept;
    assign n_eff       = accept ? cfg_tile_num : tile_num;
    assign ld_cnt_eff  = accept ? '0 : ld_cnt;
    assign ld_ptr_eff  = accept ? 1'b0 : ld_ptr;
    assign cmp_ptr_eff = accept ? 1'b0 : cmp_ptr;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign set_full[b]  = ld_done_ok & (ld_bank == 1'(b));
        assign set_empty[b] = cmp_done_ok & (cmp_bank == 1'(b));
        assign eff[b]       = bank_eff(bank_st[b], set_full[b], set_empty[b]);
        assign set_fill[b]  = ld_issue & (ld_ptr_eff == 1'(b));
        assign set_comp[b]  = cmp_issue & (cmp_ptr_eff == 1'(b));

        pp_bank_tracker u_trk (
            .clk_l     (clk_l),
            .rst_n     (rst_n),
            .set_fill  (set_fill[b]),
            .set_full  (set_full[b]),
            .set_comp  (set_comp[b]),
            .set_empty (set_empty[b]),
            .state     (bank_st[b])
        );
    end

    assign ld_issue  = run_eff & (~ld_busy | ld_done_ok) & (ld_cnt_eff < n_eff)
                     & (eff[ld_ptr_eff] == EMPTY);
    assign cmp_issue = run_eff & (~cmp_busy | cmp_done_ok)
                     & (eff[cmp_ptr_eff] == FULL);

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (layer_start) st_nxt = (cfg_tile_num != '0) ? RUN : FIN;
            RUN:     if (cmp_done_ok && cmp_cnt == tile_num - 1'b1) st_nxt = FIN;
            FIN:     st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            tile_num     <= '0;
            ld_cnt       <= '0;
            cmp_cnt      <= '0;
            ld_ptr       <= 1'b0;
            cmp_ptr      <= 1'b0;
            ld_busy      <= 1'b0;
            cmp_busy     <= 1'b0;
            ld_start     <= 1'b0;
            ld_bank      <= 1'b0;
            cmp_start    <= 1'b0;
            cmp_bank     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            ld_start  <= ld_issue;
            cmp_start <= cmp_issue;
            ld_busy   <= ld_issue | (ld_busy & ~ld_done_ok);
            cmp_busy  <= cmp_issue | (cmp_busy & ~cmp_done_ok);

            if (accept) begin
                tile_num <= cfg_tile_num;
                ld_cnt   <= '0;
                cmp_cnt  <= '0;
                ld_ptr   <= 1'b0;
                cmp_ptr  <= 1'b0;
            end
            if (ld_issue) begin
                ld_bank <= ld_ptr_eff;
                ld_ptr  <= ~ld_ptr_eff;
                ld_cnt  <= ld_cnt_eff + 1'b1;
            end
            if (cmp_issue) begin
                cmp_bank <= cmp_ptr_eff;
                cmp_ptr  <= ~cmp_ptr_eff;
            end
            if (cmp_done_ok) cmp_cnt <= cmp_cnt + 1'b1;

            if (accept)   err_spurious <= 1'b0;
            if (spurious) err_spurious <= 1'b1;
        end
    end

    assign busy       = (st == RUN);
    assign layer_done = (st == FIN);

endmodule

// File: tb/tb_actbuf_pp_sched.sv
// Directed bench for actbuf_pp_sched: a latency-model responder plays the
// loader and sblk_ctrl, expected start/done events are queued per kind.
module tb_actbuf_pp_sched;

    logic        clk_l = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_tile_num;
    logic        layer_start;
    logic        ld_start, ld_bank, ld_done;
    logic        cmp_start, cmp_bank, cmp_done;
    logic        busy, layer_done, err_spurious;

    actbuf_pp_sched #(.TILE_CNT_W(16)) dut (
        .clk_l        (clk_l),
        .rst_n        (rst_n),
        .cfg_tile_num (cfg_tile_num),
        .layer_start  (layer_start),
        .ld_start     (ld_start),
        .ld_bank      (ld_bank),
        .ld_done      (ld_done),
        .cmp_start    (cmp_start),
        .cmp_bank     (cmp_bank),
        .cmp_done     (cmp_done),
        .busy         (busy),
        .layer_done   (layer_done),
        .err_spurious (err_spurious)
    );

    always #5 clk_l = ~clk_l;

    typedef struct { int bank; int cyc; } ev_t;
    ev_t ld_q [$];
    ev_t cmp_q[$];
    ev_t dn_q [$];

    int cyc = 0;
    int base = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int busy_cyc = 0;
    int ld_lat, cmp_lat, ld_tmr, cmp_tmr;
    bit inj_cmp;

    always @(posedge clk_l) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Spec cycle of an observation = cycles since layer_start was driven.
    always @(negedge clk_l) begin : mon
        int c;
        ev_t e;
        c = cyc - base;
        if (rst_n) begin
            if (busy) busy_cyc++;
            if (ld_start) begin
                if (ld_q.size() == 0) chk("ld_start_unexpected_at", c, -1);
                else begin
                    e = ld_q.pop_front();
                    chk("ld_bank", int'(ld_bank), e.bank);
                    chk("ld_start_cycle", c, e.cyc);
                end
            end
            if (cmp_start) begin
                if (cmp_q.size() == 0) chk("cmp_start_unexpected_at", c, -1);
                else begin
                    e = cmp_q.pop_front();
                    chk("cmp_bank", int'(cmp_bank), e.bank);
                    chk("cmp_start_cycle", c, e.cyc);
                end
            end
            if (layer_done) begin
                done_seen++;
                if (dn_q.size() == 0) chk("layer_done_unexpected_at", c, -1);
                else begin
                    e = dn_q.pop_front();
                    chk("layer_done_cycle", c, e.cyc);
                end
            end
        end
    end

    task automatic push_ld(input int bank, input int c);
        ev_t e; e.bank = bank; e.cyc = c; ld_q.push_back(e);
    endtask
    task automatic push_cmp(input int bank, input int c);
        ev_t e; e.bank = bank; e.cyc = c; cmp_q.push_back(e);
    endtask
    task automatic push_done(input int c);
        ev_t e; e.bank = 0; e.cyc = c; dn_q.push_back(e);
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk_l);
        #1;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk_l); #1;
        cfg_tile_num = 16'(n);
        layer_start  = 1'b1;
        @(negedge clk_l); #1;
        layer_start  = 1'b0;
    endtask

    task automatic start_layer(input int n);
        @(negedge clk_l); #1;
        cfg_tile_num = 16'(n);
        layer_start  = 1'b1;
        base         = cyc;
        @(negedge clk_l); #1;
        layer_start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k = 0;
        while (done_seen == d0 && k < budget) begin
            @(negedge clk_l); #1;
            k++;
        end
        chk(tag, done_seen - d0, 1);
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_ld_left"},   ld_q.size(),  0);
        chk({tag, "_cmp_left"},  cmp_q.size(), 0);
        chk({tag, "_done_left"}, dn_q.size(),  0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ld_start"},  int'(ld_start),     0);
        chk({tag, "_ld_bank"},   int'(ld_bank),      0);
        chk({tag, "_cmp_start"}, int'(cmp_start),    0);
        chk({tag, "_cmp_bank"},  int'(cmp_bank),     0);
        chk({tag, "_busy"},      int'(busy),         0);
        chk({tag, "_done"},      int'(layer_done),   0);
        chk({tag, "_err"},       int'(err_spurious), 0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; layer_start = 1'b0; cfg_tile_num = '0;
        ld_done = 1'b0; cmp_done = 1'b0; inj_cmp = 1'b0;
        ld_lat = 10; cmp_lat = 20; ld_tmr = 0; cmp_tmr = 0;

        // Loader / sblk_ctrl latency model; sole driver of the done inputs.
        fork
            forever begin
                @(negedge clk_l);
                ld_done  = 1'b0;
                cmp_done = 1'b0;
                if (!rst_n) begin
                    ld_tmr = 0; cmp_tmr = 0; inj_cmp = 1'b0;
                end else begin
                    if (ld_tmr > 0) begin ld_tmr--; if (ld_tmr == 0) ld_done = 1'b1; end
                    if (cmp_tmr > 0) begin cmp_tmr--; if (cmp_tmr == 0) cmp_done = 1'b1; end
                    if (inj_cmp) begin cmp_done = 1'b1; inj_cmp = 1'b0; end
                    if (ld_start)  ld_tmr  = ld_lat;
                    if (cmp_start) cmp_tmr = cmp_lat;
                end
            end
        join_none

        wait_cycles(3);
        check_zero("reset");
        rst_n = 1'b1;

        // Test 1: single tile
        push_ld(0, 1); push_cmp(0, 12); push_done(33);
        d0 = done_seen;
        start_layer(1);
        wait_cycles(4);
        chk("t1_busy_running", int'(busy), 1);
        wait_done(d0, 200, "t1_layer_done");
        chk("t1_busy_at_done", int'(busy), 0);
        wait_cycles(1);
        chk("t1_busy_after", int'(busy), 0);
        check_q("t1");

        // Test 2: four tiles, banks alternate
        push_ld(0, 1); push_ld(1, 12); push_ld(0, 33); push_ld(1, 54);
        push_cmp(0, 12); push_cmp(1, 33); push_cmp(0, 54); push_cmp(1, 75);
        push_done(96);
        d0 = done_seen;
        start_layer(4);
        wait_done(d0, 300, "t2_layer_done");
        check_q("t2");

        // Test 3: empty layer
        push_done(1);
        busy_cyc = 0;
        d0 = done_seen;
        start_layer(0);
        wait_done(d0, 20, "t3_layer_done");
        wait_cycles(2);
        chk("t3_busy_cycles", busy_cyc, 0);
        check_q("t3");

        // Test 4: ld_done(bank1) and cmp_done(bank0) land on the same edge (22)
        ld_lat = 10; cmp_lat = 10;
        push_ld(0, 1); push_ld(1, 12); push_ld(0, 23);
        push_cmp(0, 12); push_cmp(1, 23); push_cmp(0, 34);
        push_done(45);
        d0 = done_seen;
        start_layer(3);
        wait_done(d0, 200, "t4_layer_done");
        chk("t4_cmp_cnt", int'(dut.cmp_cnt), 3);
        chk("t4_err", int'(err_spurious), 0);
        check_q("t4");

        // Test 5: mid-layer re-start ignored, spurious cmp_done in IDLE
        ld_lat = 10; cmp_lat = 20;
        push_ld(0, 1); push_ld(1, 12);
        push_cmp(0, 12); push_cmp(1, 33);
        push_done(54);
        d0 = done_seen;
        start_layer(2);
        wait_cycles(3);
        pulse_start(7);
        wait_done(d0, 200, "t5_layer_done");
        chk("t5_ld_cnt", int'(dut.ld_cnt), 2);
        chk("t5_cmp_cnt", int'(dut.cmp_cnt), 2);
        check_q("t5a");
        wait_cycles(2);
        chk("t5_err_before", int'(err_spurious), 0);
        inj_cmp = 1'b1;
        wait_cycles(3);
        chk("t5_err_set", int'(err_spurious), 1);
        chk("t5_busy_idle", int'(busy), 0);
        push_ld(0, 1); push_cmp(0, 12); push_done(33);
        d0 = done_seen;
        start_layer(1);
        chk("t5_err_cleared", int'(err_spurious), 0);
        wait_done(d0, 200, "t5_second_layer_done");
        check_q("t5b");

        // Test 6: reset while half 1 is FILLING, then a clean layer
        push_ld(0, 1); push_ld(1, 12); push_cmp(0, 12);
        start_layer(4);
        wait_cycles(14);
        chk("t6_half1_filling", int'(dut.g_bank[1].u_trk.state), 1);
        chk("t6_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_abort");
        check_q("t6a");
        wait_cycles(3);
        rst_n = 1'b1;
        push_ld(0, 1); push_ld(1, 12);
        push_cmp(0, 12); push_cmp(1, 33);
        push_done(54);
        d0 = done_seen;
        start_layer(2);
        wait_done(d0, 200, "t6_layer_done");
        chk("t6_cmp_cnt", int'(dut.cmp_cnt), 2);
        check_q("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
